regs: RTL
=========

Name: regs

Overview:
- Architectural integer register file: 32 x 32-bit, two combinational read ports and one write port.
- Serves as the responder for the decode stage's rs1/rs2 read requests.
- Accepts the destination address and write-enable that decode issues, and commits the data that writeback returns.
- Integrates a per-register pending-write scoreboard that raises a stall to decode on a read-after-write hazard the write-bypass cannot cover.

Parameters:
- XLEN, 32, data width.
- REG_NUM, 32, number of architectural registers; register 0 is hardwired zero.
- SB_MAX, 3, maximum in-flight writes tracked per register (EX, MEM, WB); counter width = clog2(SB_MAX+1).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- id_reg1_raddr_i  input  5  rs1 read address from decode
- id_reg2_raddr_i  input  5  rs2 read address from decode
- id_rs1_used_i  input  1  current decode instruction consumes rs1
- id_rs2_used_i  input  1  current decode instruction consumes rs2
- regs_reg1_rdata_o  output  XLEN  rs1 read data
- regs_reg2_rdata_o  output  XLEN  rs2 read data
- id_issue_i  input  1  decode instruction advances to EX this cycle
- id_reg_we_i  input  1  issuing instruction writes a register
- id_reg_waddr_i  input  5  issuing instruction's rd
- wb_reg_we_i  input  1  writeback commits a register this cycle
- wb_reg_waddr_i  input  5  writeback rd
- wb_reg_wdata_i  input  XLEN  writeback data
- regs_stall_o  output  1  hazard; decode must hold
- regs_sb_err_o  output  1  sticky scoreboard overflow/underflow flag

Behaviour:
- Reset (rst high at a rising edge):
  - All registers are set to 0 and all scoreboard counters are set to 0.
  - regs_sb_err_o is set to 0.
  - While rst is high, regs_stall_o is forced to 0.
  - Reset takes priority over simultaneous writes, issues and clears.
- Reads:
  - Combinational, zero latency.
  - Address 0 always returns 0.
  - Write bypass: if wb_reg_we_i=1, wb_reg_waddr_i equals the read address, and that address is nonzero, the read returns wb_reg_wdata_i in the same cycle.
  - Otherwise the read returns the array contents.
- Writes:
  - At the rising edge, if wb_reg_we_i=1 and wb_reg_waddr_i is nonzero, the register is loaded with wb_reg_wdata_i.
  - Writes to x0 are discarded.
- Hazard per source port n (rs1/rs2):
  - hz_n = used_n AND raddr_n nonzero AND cnt[raddr_n] nonzero AND NOT (wb_reg_we_i AND wb_reg_waddr_i equals raddr_n AND cnt[raddr_n]=1).
  - The exception covers the case where the last pending writer is the one being written back and bypassed this cycle.
  - regs_stall_o = hz_1 OR hz_2.
- Scoreboard set:
  - set = id_issue_i AND NOT regs_stall_o AND id_reg_we_i AND id_reg_waddr_i nonzero.
  - An issue while stalled is ignored.
- Scoreboard clear:
  - clr = wb_reg_we_i AND wb_reg_waddr_i nonzero.
- Counter update per register r, at the rising edge:
  - set only: cnt+1.
  - clr only: cnt-1.
  - set and clr on the same r: unchanged.
  - set and clr on different registers: both applied independently.
- Overflow: a set with cnt[r]=SB_MAX leaves cnt unchanged and sets regs_sb_err_o.
- Underflow: a clr with cnt[r]=0 leaves cnt at 0 and sets regs_sb_err_o.
- regs_sb_err_o stays high until rst.
- x0: its counter is never modified; x0 never produces a hazard.

Decomposition:
- Shared package holds:
  - XLEN, REG_NUM, REG_AW=5, REG_ZERO=5'd0;
  - the scoreboard counter typedef, sized from SB_MAX.
- One sub-module, regs_sb:
  - owns the counter array, set/clear/saturation logic and the error flag;
  - exports cnt_is_zero and cnt_is_one per read port to the hazard logic in regs.

Test Plan:
1. Reset then read: rst=1 for 2 cycles; read x5 and x0 -> rdata both 0, regs_stall_o=0, regs_sb_err_o=0.
2. Write then read: WB writes x3=0xDEADBEEF; next cycle read x3 -> 0xDEADBEEF. WB writes x0=0x1234; read x0 -> 0.
3. Bypass: in the same cycle WB writes x7=0xA5A5A5A5 and rs1=x7 is read -> rdata1=0xA5A5A5A5 combinationally.
4. RAW stall:
   - Issue with rd=x4 -> cnt[x4]=1.
   - Next decode uses rs2=x4 -> regs_stall_o=1 and holds.
   - In the WB cycle for x4=0x55, stall=0 and rdata2=0x55; cnt[x4]=0 afterwards.
5. Back-to-back writers:
   - Three issues with rd=x9 -> cnt=3; rs1=x9 stalls through the first two WBs.
   - Stall clears only in the third WB cycle.
   - A fourth issue at cnt=3 -> regs_sb_err_o=1, cnt stays 3.
6. Simultaneous set/clear and reset mid-flight:
   - Issue rd=x2 while WB writes x2 with cnt=1 -> cnt stays 1.
   - Assert rst with cnt[x2]=1 and a pending WB -> cnt=0, x2=0, no write applied.
   - A later WB to x2 sets regs_sb_err_o (underflow).

Source files
------------

// File: rtl/regs_pkg.sv
// Shared definitions for the integer register file and its pending-write
// scoreboard.
//   XLEN      data width of one architectural register
//   REG_NUM   number of architectural registers (x0 is hardwired zero)
//   REG_AW    register address width
//   REG_ZERO  address of x0
//   SB_MAX    most in-flight writers tracked per register (EX, MEM, WB)
//   sb_cnt_t  per-register pending-write counter, sized to hold 0..SB_MAX
package regs_pkg;

   localparam int XLEN    = 32;
   localparam int REG_NUM = 32;
   localparam int REG_AW  = 5;
   localparam int SB_MAX  = 3;
   localparam int SB_CW   = $clog2(SB_MAX + 1);

   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef logic [SB_CW-1:0] sb_cnt_t;

   localparam sb_cnt_t SB_CNT_MAX  = sb_cnt_t'(SB_MAX);
   localparam sb_cnt_t SB_CNT_ZERO = sb_cnt_t'(0);
   localparam sb_cnt_t SB_CNT_ONE  = sb_cnt_t'(1);

endpackage

// File: rtl/regs_sb.sv
// Pending-write scoreboard: one saturating counter per architectural
// register, counting writes that have issued but not yet been written back.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   i_set, i_set_addr        an instruction writing i_set_addr issued
//   i_clr, i_clr_addr        writeback committed i_clr_addr
//   i_rd1_addr, i_rd2_addr   decode source addresses to report on
//   o_rd1_cnt_zero/one       counter of rs1 is 0 / is exactly 1
//   o_rd2_cnt_zero/one       counter of rs2 is 0 / is exactly 1
//   o_err                    sticky overflow/underflow flag, cleared by rst
module regs_sb
   import regs_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_set,
   input  logic [REG_AW-1:0] i_set_addr,
   input  logic              i_clr,
   input  logic [REG_AW-1:0] i_clr_addr,
   input  logic [REG_AW-1:0] i_rd1_addr,
   input  logic [REG_AW-1:0] i_rd2_addr,
   output logic              o_rd1_cnt_zero,
   output logic              o_rd1_cnt_one,
   output logic              o_rd2_cnt_zero,
   output logic              o_rd2_cnt_one,
   output logic              o_err
);

   sb_cnt_t r_cnt     [REG_NUM];
   sb_cnt_t w_cnt_nxt [REG_NUM];
   logic    r_err;

   logic w_set_v;
   logic w_clr_v;
   logic w_same;
   logic w_ovf;
   logic w_udf;

   // x0 is never tracked, even if a caller presents it.
   assign w_set_v = i_set && (i_set_addr != REG_ZERO);
   assign w_clr_v = i_clr && (i_clr_addr != REG_ZERO);

   // A set and clear on the same register cancel, so neither can saturate.
   assign w_same = w_set_v && w_clr_v && (i_set_addr == i_clr_addr);
   assign w_ovf  = w_set_v && !w_same && (r_cnt[i_set_addr] == SB_CNT_MAX);
   assign w_udf  = w_clr_v && !w_same && (r_cnt[i_clr_addr] == SB_CNT_ZERO);

   always_comb begin
      for (int i = 0; i < REG_NUM; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
      end
      w_cnt_nxt[0] = SB_CNT_ZERO;
      for (int i = 1; i < REG_NUM; i++) begin
         if (w_set_v && !w_same && (i_set_addr == REG_AW'(i)) &&
             (r_cnt[i] != SB_CNT_MAX)) begin
            w_cnt_nxt[i] = r_cnt[i] + SB_CNT_ONE;
         end
         if (w_clr_v && !w_same && (i_clr_addr == REG_AW'(i)) &&
             (r_cnt[i] != SB_CNT_ZERO)) begin
            w_cnt_nxt[i] = r_cnt[i] - SB_CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_cnt[i] <= SB_CNT_ZERO;
         end
         r_err <= 1'b0;
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
         r_err <= r_err | w_ovf | w_udf;
      end
   end

   assign o_rd1_cnt_zero = (r_cnt[i_rd1_addr] == SB_CNT_ZERO);
   assign o_rd1_cnt_one  = (r_cnt[i_rd1_addr] == SB_CNT_ONE);
   assign o_rd2_cnt_zero = (r_cnt[i_rd2_addr] == SB_CNT_ZERO);
   assign o_rd2_cnt_one  = (r_cnt[i_rd2_addr] == SB_CNT_ONE);
   assign o_err          = r_err;

endmodule

// File: rtl/regs.sv
// Architectural integer register file (32 x 32-bit, x0 hardwired zero) with
// two combinational read ports, one write port with same-cycle write bypass,
// and a pending-write scoreboard that stalls decode on unresolved RAW hazards.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_reg1_raddr_i/id_rs1_used_i  rs1 address and use flag from decode
//   id_reg2_raddr_i/id_rs2_used_i  rs2 address and use flag from decode
//   regs_reg1_rdata_o/reg2         read data (bypassed from writeback)
//   id_issue_i, id_reg_we_i,
//   id_reg_waddr_i                 decode issue and its destination
//   wb_reg_we_i/waddr_i/wdata_i    writeback commit
//   regs_stall_o                   decode must hold its instruction
//   regs_sb_err_o                  sticky scoreboard overflow/underflow
//
// Issue contract: decode offers an instruction with id_issue_i; it is taken
// only in a cycle where regs_stall_o is low. An issue presented while
// regs_stall_o is high is ignored and decode must present it again.
module regs
   import regs_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_reg1_raddr_i,
   input  logic [REG_AW-1:0] id_reg2_raddr_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   output logic [XLEN-1:0]   regs_reg1_rdata_o,
   output logic [XLEN-1:0]   regs_reg2_rdata_o,
   input  logic              id_issue_i,
   input  logic              id_reg_we_i,
   input  logic [REG_AW-1:0] id_reg_waddr_i,
   input  logic              wb_reg_we_i,
   input  logic [REG_AW-1:0] wb_reg_waddr_i,
   input  logic [XLEN-1:0]   wb_reg_wdata_i,
   output logic              regs_stall_o,
   output logic              regs_sb_err_o
);

   logic [XLEN-1:0] r_rf [REG_NUM];

   logic w_wb_v;
   logic w_set;
   logic w_stall;
   logic w_hz1;
   logic w_hz2;
   logic w_rd1_zero;
   logic w_rd1_one;
   logic w_rd2_zero;
   logic w_rd2_one;

   assign w_wb_v = wb_reg_we_i && (wb_reg_waddr_i != REG_ZERO);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_rf[i] <= '0;
         end
      end else if (w_wb_v) begin
         r_rf[wb_reg_waddr_i] <= wb_reg_wdata_i;
      end
   end

   // Reads: x0 is zero, then writeback bypass, then the array.
   always_comb begin
      regs_reg1_rdata_o = r_rf[id_reg1_raddr_i];
      if (id_reg1_raddr_i == REG_ZERO) begin
         regs_reg1_rdata_o = '0;
      end else if (w_wb_v && (wb_reg_waddr_i == id_reg1_raddr_i)) begin
         regs_reg1_rdata_o = wb_reg_wdata_i;
      end
      regs_reg2_rdata_o = r_rf[id_reg2_raddr_i];
      if (id_reg2_raddr_i == REG_ZERO) begin
         regs_reg2_rdata_o = '0;
      end else if (w_wb_v && (wb_reg_waddr_i == id_reg2_raddr_i)) begin
         regs_reg2_rdata_o = wb_reg_wdata_i;
      end
   end

   // A source is ready if nothing is pending, or if the only pending writer
   // is the one being written back (and bypassed) this very cycle.
   assign w_hz1 = id_rs1_used_i && (id_reg1_raddr_i != REG_ZERO) && !w_rd1_zero &&
                  !(w_wb_v && (wb_reg_waddr_i == id_reg1_raddr_i) && w_rd1_one);
   assign w_hz2 = id_rs2_used_i && (id_reg2_raddr_i != REG_ZERO) && !w_rd2_zero &&
                  !(w_wb_v && (wb_reg_waddr_i == id_reg2_raddr_i) && w_rd2_one);

   assign w_stall      = !rst && (w_hz1 || w_hz2);
   assign regs_stall_o = w_stall;

   assign w_set = id_issue_i && !w_stall && id_reg_we_i && (id_reg_waddr_i != REG_ZERO);

   regs_sb u_sb (
      .clk            (clk),
      .rst            (rst),
      .i_set          (w_set),
      .i_set_addr     (id_reg_waddr_i),
      .i_clr          (w_wb_v),
      .i_clr_addr     (wb_reg_waddr_i),
      .i_rd1_addr     (id_reg1_raddr_i),
      .i_rd2_addr     (id_reg2_raddr_i),
      .o_rd1_cnt_zero (w_rd1_zero),
      .o_rd1_cnt_one  (w_rd1_one),
      .o_rd2_cnt_zero (w_rd2_zero),
      .o_rd2_cnt_one  (w_rd2_one),
      .o_err          (regs_sb_err_o)
   );

endmodule
